alu_writeback: RTL

Result and flags commit stage directly downstream of the ALU. It accepts one ALU result per handshake and drives the register-file write port: one write for ordinary ops, two for 16-bit MUL/IMUL (AX then DX). It also owns the architectural FLAGS register and merges ALU `flags_out` under a per-op update mask. It exports the committed FLAGS value back to the ALU `flags_in`.

---
 rtl/alu_writeback_pkg.sv | 39 +++
 rtl/alu_writeback_if.sv | 26 ++
 rtl/alu_writeback_flags_reg.sv | 33 +++
 rtl/alu_writeback.sv | 92 +++++++++
 4 files changed

// File: rtl/alu_writeback_pkg.sv
// Shared constants and types for the ALU result/flags commit stage.
package alu_writeback_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned RES_W  = 32;
    localparam int unsigned SEL_W  = 3;

    // FLAGS bit positions, same numbering as the ALU
    localparam int unsigned CF_IDX = 0;
    localparam int unsigned PF_IDX = 2;
    localparam int unsigned AF_IDX = 4;
    localparam int unsigned ZF_IDX = 6;
    localparam int unsigned SF_IDX = 7;
    localparam int unsigned TF_IDX = 8;
    localparam int unsigned IF_IDX = 9;
    localparam int unsigned DF_IDX = 10;
    localparam int unsigned OF_IDX = 11;

    localparam int unsigned AX_IDX = 0;
    localparam int unsigned DX_IDX = 2;

    localparam logic [DATA_W-1:0] FLAGS_RESET = 16'hF002;
    localparam logic [DATA_W-1:0] FIXED_ONES  = 16'hF002;
    localparam logic [DATA_W-1:0] FIXED_ZEROS = 16'h0028;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic              en;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] val;
        logic              is_8_bit;
    } reg_wr_t;

endpackage

// File: rtl/alu_writeback_if.sv
// ALU-to-writeback result handshake.
interface alu_writeback_if;
    import alu_writeback_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [RES_W-1:0]  in_result;
    logic [DATA_W-1:0] in_flags;
    logic [DATA_W-1:0] in_flags_mask;
    logic              in_is_8_bit;
    logic              in_wide;
    logic              in_dest_valid;
    logic [SEL_W-1:0]  in_dest;

    modport master (
        output in_valid, in_result, in_flags, in_flags_mask,
               in_is_8_bit, in_wide, in_dest_valid, in_dest,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_result, in_flags, in_flags_mask,
               in_is_8_bit, in_wide, in_dest_valid, in_dest,
        output in_ready
    );
endinterface

// File: rtl/alu_writeback_flags_reg.sv
// Architectural FLAGS register: masked merge with forced-one/forced-zero bits.
module flags_reg
    import alu_writeback_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              upd_i,
    input  logic [DATA_W-1:0] flags_i,
    input  logic [DATA_W-1:0] mask_i,
    output logic [DATA_W-1:0] flags_o
);

    logic [DATA_W-1:0] flags_q;
    logic [DATA_W-1:0] flags_d;

    always_comb begin
        flags_d = flags_q;
        if (upd_i) begin
            flags_d = ((flags_q & ~mask_i) | (flags_i & mask_i) | FIXED_ONES) & ~FIXED_ZEROS;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= FLAGS_RESET;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags_o = flags_q;

endmodule

// File: rtl/alu_writeback.sv
// Commits ALU results to the register-file write port (AX then DX for wide
// multiplies) and owns the architectural FLAGS register.
module alu_writeback
    import alu_writeback_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    alu_writeback_if.slave    in_bus,
    output logic              reg_wr_en,
    output logic [SEL_W-1:0]  reg_wr_sel,
    output logic [DATA_W-1:0] reg_wr_val,
    output logic              reg_wr_8_bit,
    output logic [DATA_W-1:0] flags,
    output logic              done
);

    wb_state_e         state_q;
    logic              hi_pending_q;
    logic [DATA_W-1:0] hi_val_q;
    reg_wr_t           wr_q;
    logic              done_q;

    reg_wr_t           lo_wr;
    reg_wr_t           hi_wr;
    logic              accept;
    logic              in_hi_pending;

    // Only the LO cycle of a 16-bit multiply blocks new work
    assign in_bus.in_ready = (state_q == IDLE)
                           | ((state_q == WR_LO) & ~hi_pending_q)
                           | (state_q == WR_HI);
    assign accept        = in_bus.in_valid & in_bus.in_ready;
    assign in_hi_pending = in_bus.in_wide & ~in_bus.in_is_8_bit;

    always_comb begin
        lo_wr.en       = in_bus.in_dest_valid;
        lo_wr.sel      = in_bus.in_dest;
        lo_wr.val      = in_bus.in_result[DATA_W-1:0];
        lo_wr.is_8_bit = in_bus.in_is_8_bit;
        if (in_bus.in_wide) begin
            lo_wr.en       = 1'b1;
            lo_wr.sel      = SEL_W'(AX_IDX);
            lo_wr.is_8_bit = 1'b0;
        end
        hi_wr.en       = 1'b1;
        hi_wr.sel      = SEL_W'(DX_IDX);
        hi_wr.val      = hi_val_q;
        hi_wr.is_8_bit = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            hi_pending_q <= 1'b0;
            hi_val_q     <= '0;
            wr_q         <= '0;
            done_q       <= 1'b0;
        end else if (accept) begin
            state_q      <= WR_LO;
            hi_pending_q <= in_hi_pending;
            hi_val_q     <= in_bus.in_result[RES_W-1:DATA_W];
            wr_q         <= lo_wr;
            done_q       <= ~in_hi_pending;
        end else if ((state_q == WR_LO) && hi_pending_q) begin
            state_q      <= WR_HI;
            hi_pending_q <= 1'b0;
            wr_q         <= hi_wr;
            done_q       <= 1'b1;
        end else begin
            state_q      <= IDLE;
            hi_pending_q <= 1'b0;
            wr_q.en      <= 1'b0;
            done_q       <= 1'b0;
        end
    end

    flags_reg u_flags_reg (
        .clk     (clk),
        .reset   (reset),
        .upd_i   (accept),
        .flags_i (in_bus.in_flags),
        .mask_i  (in_bus.in_flags_mask),
        .flags_o (flags)
    );

    assign reg_wr_en    = wr_q.en;
    assign reg_wr_sel   = wr_q.sel;
    assign reg_wr_val   = wr_q.val;
    assign reg_wr_8_bit = wr_q.is_8_bit;
    assign done         = done_q;

endmodule
